// File: rtl/br_pkg.sv
// Shared encodings for branch resolution: funct3 codes,
// 2-bit BHT counter states and the BHT init FSM.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
  localparam logic [1:0] CNT_RST = CNT_WNT;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [1:0] cnt_next(
    input logic [1:0] c,
    input logic       up
  );
    logic [1:0] n;
    n = c;
    if (up && c != CNT_ST)
      n = c + 2'd1;
    else if (!up && c != CNT_SNT)
      n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit saturating counters with an
// init sweep after reset, one read port and one update port.
module br_bht
  import br_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            ready
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam logic [IDXW-1:0] LAST = IDXW'(ENTRIES - 1);

  logic [0:0]      state;
  logic [IDXW-1:0] init_idx;
  logic [1:0]      cnt [ENTRIES];
  logic [IDXW-1:0] rd_idx;
  logic [IDXW-1:0] upd_idx;
  logic            unused_bits;

  assign rd_idx  = rd_pc[IDXW+1:2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign unused_bits = ^{rd_pc[XLEN-1:IDXW+2], rd_pc[1:0],
                         upd_pc[XLEN-1:IDXW+2], upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == LAST)
        state <= ST_RUN;
    end
  end

  // Array has no reset; the sweep owns the write port during INIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        cnt[init_idx] <= CNT_RST;
      else if (upd_en)
        cnt[upd_idx] <= cnt_next(cnt[upd_idx], upd_taken);
    end
  end

  assign ready    = (state == ST_RUN);
  assign rd_taken = ready & cnt[rd_idx][1];

endmodule

// File: rtl/br_resolve.sv
// Execute-stage branch resolve + BHT prediction.
// Optional perf counters: define BR_RESOLVE_PERF_EN.
module br_resolve
  import br_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_jump,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic            br_less,
  input  logic            br_equal,
  output logic            br_unsigned,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
`ifdef BR_RESOLVE_PERF_EN
  output logic [XLEN-1:0] perf_branches,
  output logic [XLEN-1:0] perf_mispredicts,
`endif
  output logic            bht_ready
);

  logic            cond;
  logic            legal;
  logic            taken;
  logic            mispredict;
  logic            is_branch;
  logic [XLEN-1:0] fix_pc;

  assign br_unsigned = ex_funct3[1];

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (ex_funct3)
      F3_BEQ:           cond = br_equal;
      F3_BNE:           cond = !br_equal;
      F3_BLT, F3_BLTU:  cond = br_less;
      F3_BGE, F3_BGEU:  cond = !br_less;
      default:          legal = 1'b0;
    endcase
  end

  assign taken      = ex_is_jump | cond;
  assign mispredict = ex_valid & (taken != ex_pred_taken);
  assign is_branch  = ex_valid & !ex_is_jump & legal;
  assign fix_pc     = taken ? ex_target : ex_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict)
        redirect_pc <= fix_pc;
    end
  end

  br_bht #(
    .ENTRIES (BHT_ENTRIES),
    .XLEN    (XLEN)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pred_pc),
    .rd_taken  (pred_taken),
    .upd_en    (is_branch),
    .upd_pc    (ex_pc),
    .upd_taken (taken),
    .ready     (bht_ready)
  );

`ifdef BR_RESOLVE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (is_branch && perf_branches != '1)
        perf_branches <= perf_branches + 1'b1;
      if (mispredict && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve against a
// behavioural model of branch outcome and BHT state.
module tb_br_resolve;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_is_jump = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic        br_less = 1'b0;
  logic        br_equal = 1'b0;
  logic        br_unsigned;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bht_ready;
`ifdef BR_RESOLVE_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  int unsigned m_pb = 0;
  int unsigned m_pm = 0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // model state
  int          m_bht [N];
  int          m_cyc = 0;
  bit          m_ready = 0;
  bit          e_red = 0;
  logic [31:0] e_rpc = '0;

  always #5 clk = ~clk;

  br_resolve #(.BHT_ENTRIES(N), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .ex_valid      (ex_valid),
    .ex_is_jump    (ex_is_jump),
    .ex_funct3     (ex_funct3),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .br_less       (br_less),
    .br_equal      (br_equal),
    .br_unsigned   (br_unsigned),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
`ifdef BR_RESOLVE_PERF_EN
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts),
`endif
    .bht_ready     (bht_ready)
  );

  function automatic bit ref_legal(logic [2:0] f);
    return !(f == 3'b010 || f == 3'b011);
  endfunction

  function automatic bit ref_taken(bit j, logic [2:0] f, bit lt, bit eq);
    bit c;
    case (f)
      3'b000: c = eq;
      3'b001: c = !eq;
      3'b100, 3'b110: c = lt;
      3'b101, 3'b111: c = !lt;
      default: c = 0;
    endcase
    return j | c;
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'(pc / 4) % N;
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_ready && (m_bht[idx_of(pc)] >= 2);
  endfunction

  // Advance the model over one clock edge using current inputs.
  task automatic tick();
    bit tk;
    int i;
    if (rst) begin
      m_cyc = 0;
      m_ready = 0;
      e_red = 0;
      e_rpc = '0;
      foreach (m_bht[k]) m_bht[k] = 1;
`ifdef BR_RESOLVE_PERF_EN
      m_pb = 0;
      m_pm = 0;
`endif
    end else begin
      tk = ref_taken(ex_is_jump, ex_funct3, br_less, br_equal);
      e_red = ex_valid && (tk != ex_pred_taken);
      if (e_red) e_rpc = tk ? ex_target : ex_pc + 32'd4;
      if (ex_valid && !ex_is_jump && ref_legal(ex_funct3)) begin
        i = idx_of(ex_pc);
        if (m_ready) m_bht[i] = tk ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                                   : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
`ifdef BR_RESOLVE_PERF_EN
        m_pb++;
`endif
      end
`ifdef BR_RESOLVE_PERF_EN
      if (e_red) m_pm++;
`endif
      m_cyc++;
      m_ready = (m_cyc >= N);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit j, logic [2:0] f, logic [31:0] pc,
                       logic [31:0] tgt, bit pt, bit lt, bit eq);
    ex_valid = v;
    ex_is_jump = j;
    ex_funct3 = f;
    ex_pc = pc;
    ex_target = tgt;
    ex_pred_taken = pt;
    br_less = lt;
    br_equal = eq;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_checks++;
    if (redirect !== 1'b0)
      $display("FAIL reset_redirect got %0b want 0", redirect);
    if (redirect !== 1'b0) n_fail++;
    n_checks++;
    if (redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_redirect_pc got %h want 0", redirect_pc);
    end
    rst = 0;
    for (int i = 0; i < N; i++) begin
      pred_pc = $urandom & 32'hFFFF_FFFC;
      #1;
      n_checks++;
      if (bht_ready !== m_ready || pred_taken !== m_pred(pred_pc)) begin
        n_fail++;
        $display("FAIL init_cycle%0d ready=%0b pred=%0b want ready=%0b pred=%0b",
                 i, bht_ready, pred_taken, m_ready, m_pred(pred_pc));
      end
      tick();
    end
    n_checks++;
    if (bht_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_at_%0d got %0b want 1", N, bht_ready);
    end
  endtask

  task automatic test_bltu();
    drive(1, 0, 3'b110, 32'h200, 32'h100, 0, 1, 0);
    #1;
    n_checks++;
    if (br_unsigned !== 1'b1) begin
      n_fail++;
      $display("FAIL bltu_unsigned got %0b want 1", br_unsigned);
    end
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    n_checks++;
    if (redirect !== e_red || redirect_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL bltu_redirect got %0b/%h want %0b/00000100",
               redirect, redirect_pc, e_red);
    end
    tick();
    n_checks++;
    if (redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL bltu_pulse_end got %0b want 0", redirect);
    end
  endtask

  task automatic test_wrap();
    drive(1, 0, 3'b000, 32'hFFFF_FFFC, 32'h1234, 1, 0, 0);
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL beq_wrap got %0b/%h want 1/00000000",
               redirect, redirect_pc);
    end
  endtask

  task automatic test_saturate();
    bit exp_seq [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit tk;
    pred_pc = 32'h40;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (pred_taken !== m_pred(pred_pc) || pred_taken !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL sat_step%0d got %0b want %0b", i, pred_taken, exp_seq[i]);
      end
      if (i == 7) break;
      tk = (i < 5);
      drive(1, 0, 3'b000, 32'h40, 32'h80, tk, 0, tk);
      tick();
      drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_same_cycle();
    pred_pc = 32'h14;
    drive(1, 0, 3'b001, 32'h14, 32'h80, 1, 0, 0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || m_pred(pred_pc) !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_old got %0b want 0", pred_taken);
    end
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || m_pred(pred_pc) !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_new got %0b want 1", pred_taken);
    end
  endtask

  task automatic test_illegal();
    pred_pc = 32'h40;
    drive(1, 0, 3'b010, 32'h40, 32'h999, 1, 1, 1);
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h44) begin
      n_fail++;
      $display("FAIL illegal_redirect got %0b/%h want 1/00000044",
               redirect, redirect_pc);
    end
    n_checks++;
    if (pred_taken !== m_pred(pred_pc)) begin
      n_fail++;
      $display("FAIL illegal_bht got %0b want %0b", pred_taken, m_pred(pred_pc));
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 3'b000, 32'h300, 32'h500, 0, 0, 0);
    tick();
    drive(1, 0, 3'b101, 32'h600, 32'h700, 1, 1, 0);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL b2b_first got %0b/%h want 1/00000500", redirect, redirect_pc);
    end
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h604) begin
      n_fail++;
      $display("FAIL b2b_second got %0b/%h want 1/00000604", redirect, redirect_pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 400; i++) begin
      pc = 32'h40 + 4 * $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            3'($urandom), pc, $urandom, $urandom, $urandom, $urandom);
      pred_pc = ($urandom_range(0, 1) == 1) ? pc : 32'h40 + 4 * $urandom_range(0, 7);
      #1;
      n_checks++;
      if (br_unsigned !== ex_funct3[1] || pred_taken !== m_pred(pred_pc)) begin
        n_fail++;
        $display("FAIL rand%0d_comb uns=%0b pred=%0b want %0b/%0b", i,
                 br_unsigned, pred_taken, ex_funct3[1], m_pred(pred_pc));
      end
      tick();
      n_checks++;
      if (redirect !== e_red || (e_red && redirect_pc !== e_rpc)) begin
        n_fail++;
        $display("FAIL rand%0d_redirect got %0b/%h want %0b/%h", i,
                 redirect, redirect_pc, e_red, e_rpc);
      end
    end
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
`ifdef BR_RESOLVE_PERF_EN
    n_checks++;
    if (perf_branches !== m_pb || perf_mispredicts !== m_pm) begin
      n_fail++;
      $display("FAIL perf got %0d/%0d want %0d/%0d",
               perf_branches, perf_mispredicts, m_pb, m_pm);
    end
`endif
  endtask

  task automatic test_reset_mid_init();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 30; i++) tick();
    drive(1, 0, 3'b000, 32'h80, 32'h90, 0, 0, 1);
    tick();
    n_checks++;
    if (redirect !== 1'b1 || bht_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_redirect got %0b ready %0b want 1/0",
               redirect, bht_ready);
    end
    rst = 1;
    tick();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
    n_checks++;
    if (redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_clear got %0b want 0", redirect);
    end
    rst = 0;
    for (int i = 0; i < N; i++) begin
      #1;
      n_checks++;
      if (bht_ready !== m_ready || bht_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reinit_cycle%0d ready=%0b want 0", i, bht_ready);
      end
      tick();
    end
    n_checks++;
    if (bht_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reinit_ready got %0b want 1", bht_ready);
    end
  endtask

  initial begin
    test_reset();
    test_bltu();
    test_wrap();
    test_saturate();
    test_same_cycle();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_init();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
